// File: rtl/param_seq_datapath.sv
// Parametrised single-bus datapath with a built-in micro-sequencer for one ALU op (IDLE/TA/TB/TC/TD/DONE).
// Optional build macro DP_R0_ZERO_EN: R0 reads as zero and ignores writes.
module param_seq_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int RA_W      = $clog2(NUM_REGS)
) (
    input  logic                  clock_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [3:0]            op_i,
    input  logic [RA_W-1:0]       ra_i,
    input  logic [RA_W-1:0]       rb_i,
    input  logic [RA_W-1:0]       rc_i,
    input  logic                  imm_sel_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic                  ld_en_i,
    input  logic [RA_W-1:0]       ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic [RA_W-1:0]       dbg_addr_i,
    output logic [DATA_WIDTH-1:0] dbg_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] hi_out_o,
    output logic [DATA_WIDTH-1:0] lo_out_o,
    output logic [DATA_WIDTH-1:0] bus_out_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

`ifdef DP_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TA   = 3'd1,
        S_TB   = 3'd2,
        S_TC   = 3'd3,
        S_TD   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q;
    logic [RA_W-1:0]         ra_q, rb_q, rc_q;
    logic                    imm_sel_q;
    logic [DATA_WIDTH-1:0]   imm_q, y_q, hi_q, lo_q;
    logic [2*DATA_WIDTH-1:0] z_q, alu_s;
    logic [DATA_WIDTH-1:0]   gpr_q [NUM_REGS];
    logic                    busy_q, done_q;
    logic [DATA_WIDTH-1:0]   bus_s;
    logic                    wr_req_s, wr_en_s;
    logic [RA_W-1:0]         wr_addr_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;

    function automatic logic [DATA_WIDTH-1:0] gpr_rd(input logic [RA_W-1:0] addr,
                                                     input logic [DATA_WIDTH-1:0] val);
        if (R0_ZERO && (addr == {RA_W{1'b0}})) begin
            return {DATA_WIDTH{1'b0}};
        end else begin
            return val;
        end
    endfunction

    function automatic logic [2*DATA_WIDTH-1:0] alu(input logic [3:0] op,
                                                    input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        logic [SH_W-1:0]         amt;
        logic [2*DATA_WIDTH-1:0] ax, bx;
        amt = b[SH_W-1:0];
        ax  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        bx  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        case (op)
            OP_ADD:  return {{DATA_WIDTH{1'b0}}, a + b};
            OP_SUB:  return {{DATA_WIDTH{1'b0}}, a - b};
            OP_AND:  return {{DATA_WIDTH{1'b0}}, a & b};
            OP_OR:   return {{DATA_WIDTH{1'b0}}, a | b};
            OP_XOR:  return {{DATA_WIDTH{1'b0}}, a ^ b};
            OP_SHL:  return {{DATA_WIDTH{1'b0}}, a << amt};
            OP_SHR:  return {{DATA_WIDTH{1'b0}}, a >> amt};
            // Sign-extended operands make the truncated product the exact signed result.
            OP_MUL:  return ax * bx;
            OP_NOT:  return {{DATA_WIDTH{1'b0}}, ~b};
            default: return {2*DATA_WIDTH{1'b0}};
        endcase
    endfunction

    // Shared bus source selected by the current T-state.
    always_comb begin
        bus_s = {DATA_WIDTH{1'b0}};
        case (state_q)
            S_TA:    bus_s = gpr_rd(ra_q, gpr_q[ra_q]);
            S_TB:    bus_s = imm_sel_q ? imm_q : gpr_rd(rb_q, gpr_q[rb_q]);
            S_TC:    bus_s = z_q[DATA_WIDTH-1:0];
            S_TD:    bus_s = z_q[2*DATA_WIDTH-1:DATA_WIDTH];
            default: bus_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign alu_s = alu(op_q, y_q, bus_s);

    // Sequencer next state and the single GPR write port (direct load or TC writeback).
    always_comb begin
        state_d   = state_q;
        wr_req_s  = 1'b0;
        wr_addr_s = rc_q;
        wr_data_s = bus_s;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_TA;
                end else if (ld_en_i) begin
                    wr_req_s  = 1'b1;
                    wr_addr_s = ld_addr_i;
                    wr_data_s = ld_data_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TA: state_d = S_TB;
            S_TB: state_d = S_TC;
            S_TC: begin
                if (op_q == OP_MUL) begin
                    state_d = S_TD;
                end else begin
                    state_d  = S_DONE;
                    wr_req_s = 1'b1;
                end
            end
            S_TD:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        wr_en_s = wr_req_s && !(R0_ZERO && (wr_addr_s == {RA_W{1'b0}}));
    end

    // Sequencer, operand latches, Y/Z/HI/LO and registered status outputs.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_q      <= 4'd0;
            ra_q      <= {RA_W{1'b0}};
            rb_q      <= {RA_W{1'b0}};
            rc_q      <= {RA_W{1'b0}};
            imm_sel_q <= 1'b0;
            imm_q     <= {DATA_WIDTH{1'b0}};
            y_q       <= {DATA_WIDTH{1'b0}};
            z_q       <= {2*DATA_WIDTH{1'b0}};
            hi_q      <= {DATA_WIDTH{1'b0}};
            lo_q      <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (state_q == S_IDLE && start_i) begin
                op_q      <= op_i;
                ra_q      <= ra_i;
                rb_q      <= rb_i;
                rc_q      <= rc_i;
                imm_sel_q <= imm_sel_i;
                imm_q     <= imm_i;
            end
            if (state_q == S_TA) y_q <= bus_s;
            if (state_q == S_TB) z_q <= alu_s;
            if (state_q == S_TC && op_q == OP_MUL) lo_q <= bus_s;
            if (state_q == S_TD) hi_q <= bus_s;
        end
    end

    // General-purpose register file.
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            gpr_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign dbg_data_o = gpr_rd(dbg_addr_i, gpr_q[dbg_addr_i]);
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = z_q[DATA_WIDTH-1:0];
    assign hi_out_o   = hi_q;
    assign lo_out_o   = lo_q;
    assign bus_out_o  = bus_s;

endmodule

// File: tb/tb_param_seq_datapath.sv
// Directed self-checking bench for param_seq_datapath: a 32-bit/16-reg instance and an 8-bit/4-reg instance.
module tb_param_seq_datapath;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, start, imm_sel, ld_en;
    logic [3:0]  op, ra, rb, rc, ld_addr, dbg_addr;
    logic [31:0] imm, ld_data, dbg_data, result, hi, lo, bus;
    logic        busy, done;

    logic        b_clear, b_start, b_imm_sel, b_ld_en;
    logic [3:0]  b_op;
    logic [1:0]  b_ra, b_rb, b_rc, b_ld_addr, b_dbg_addr;
    logic [7:0]  b_imm, b_ld_data, b_dbg_data, b_result, b_hi, b_lo, b_bus;
    logic        b_busy, b_done;

    int n_chk  = 0;
    int n_pass = 0;

    param_seq_datapath #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clock_i(clk), .clear_i(clear), .start_i(start), .op_i(op),
        .ra_i(ra), .rb_i(rb), .rc_i(rc), .imm_sel_i(imm_sel), .imm_i(imm),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data), .busy_o(busy), .done_o(done),
        .result_o(result), .hi_out_o(hi), .lo_out_o(lo), .bus_out_o(bus)
    );

    param_seq_datapath #(.DATA_WIDTH(8), .NUM_REGS(4)) dut8 (
        .clock_i(clk), .clear_i(b_clear), .start_i(b_start), .op_i(b_op),
        .ra_i(b_ra), .rb_i(b_rb), .rc_i(b_rc), .imm_sel_i(b_imm_sel), .imm_i(b_imm),
        .ld_en_i(b_ld_en), .ld_addr_i(b_ld_addr), .ld_data_i(b_ld_data),
        .dbg_addr_i(b_dbg_addr), .dbg_data_o(b_dbg_data), .busy_o(b_busy), .done_o(b_done),
        .result_o(b_result), .hi_out_o(b_hi), .lo_out_o(b_lo), .bus_out_o(b_bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Launch one op and return the number of edges after the start edge until done is seen.
    task automatic run(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic s, input logic [31:0] im, output int lat);
        op = o; ra = a; rb = b; rc = c; imm_sel = s; imm = im; start = 1'b1;
        tick();
        start = 1'b0; ld_en = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        tick();
        chk("idle_after_op", {busy, done}, 2'b00);
    endtask

    task automatic bload(input logic [1:0] a, input logic [7:0] d);
        b_ld_en = 1'b1; b_ld_addr = a; b_ld_data = d;
        tick();
        b_ld_en = 1'b0;
    endtask

    task automatic brun(input logic [3:0] o, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic s, input logic [7:0] im);
        b_op = o; b_ra = a; b_rb = b; b_rc = c; b_imm_sel = s; b_imm = im; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    initial begin
        int          lat, ndone;
        logic [31:0] v, acc;

        clear = 1'b1; start = 1'b0; imm_sel = 1'b0; ld_en = 1'b0;
        op = 4'd0; ra = 4'd0; rb = 4'd0; rc = 4'd0; ld_addr = 4'd0; dbg_addr = 4'd0;
        imm = 32'd0; ld_data = 32'd0;
        b_clear = 1'b1; b_start = 1'b0; b_imm_sel = 1'b0; b_ld_en = 1'b0; b_op = 4'd0;
        b_ra = 2'd0; b_rb = 2'd0; b_rc = 2'd0; b_ld_addr = 2'd0; b_dbg_addr = 2'd0;
        b_imm = 8'd0; b_ld_data = 8'd0;
        tick(); tick();
        clear = 1'b0; b_clear = 1'b0;

        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_result", result, 32'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_bus", bus, 32'd0);
        peek(4'd5, v); chk("rst_r5", v, 32'd0);
        chk("rst8_state", {b_busy, b_done, b_bus, b_result}, 18'd0);

        // ADD with cycle-by-cycle bus and latency observation.
        load(4'd1, 32'd5);
        load(4'd2, 32'd7);
        peek(4'd1, v); chk("ld_r1", v, 32'd5);
        op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; imm_sel = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("add_ta_bus", bus, 32'd5);
        chk("add_ta_busy", {busy, done}, 2'b10);
        tick(); chk("add_tb_bus", bus, 32'd7);
        tick(); chk("add_tc_bus", bus, 32'd12);
        peek(4'd3, v); chk("add_r3_pre", v, 32'd0);
        tick(); chk("add_done", {busy, done}, 2'b11);
        chk("add_done_bus", bus, 32'd0);
        peek(4'd3, v); chk("add_r3", v, 32'd12);
        chk("add_result", result, 32'd12);
        tick(); chk("add_idle", {busy, done}, 2'b00);

        // Signed MUL: -3 * 6.
        load(4'd4, 32'hFFFF_FFFD);
        load(4'd5, 32'd6);
        run(4'd7, 4'd4, 4'd5, 4'd8, 1'b0, 32'd0, lat);
        chk("mul_lat", lat, 4);
        chk("mul_lo", lo, 32'hFFFF_FFEE);
        chk("mul_hi", hi, 32'hFFFF_FFFF);
        chk("mul_result", result, 32'hFFFF_FFEE);
        peek(4'd8, v); chk("mul_no_gpr_wr", v, 32'd0);
        peek(4'd4, v); chk("mul_r4_kept", v, 32'hFFFF_FFFD);

        // SHL by immediate 35 uses only the low 5 bits (3).
        load(4'd6, 32'd1);
        run(4'd5, 4'd6, 4'd0, 4'd7, 1'b1, 32'd35, lat);
        chk("shl_lat", lat, 3);
        peek(4'd7, v); chk("shl_r7", v, 32'h8);
        chk("shl_hilo_hold", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEE});

        run(4'd1, 4'd1, 4'd2, 4'd1, 1'b0, 32'd0, lat);
        peek(4'd1, v); chk("sub_r1_alias", v, 32'hFFFF_FFFE);

        // start and ld_en together: op runs, load dropped.
        ld_en = 1'b1; ld_addr = 4'd9; ld_data = 32'h55;
        run(4'd3, 4'd2, 4'd2, 4'd10, 1'b0, 32'd0, lat);
        peek(4'd10, v); chk("start_ld_r10", v, 32'd7);
        peek(4'd9, v); chk("start_ld_r9", v, 32'd0);

        // start/ld_en/operand changes while in TB are ignored.
        op = 4'd3; ra = 4'd2; rb = 4'd5; rc = 4'd11; imm_sel = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        start = 1'b1; op = 4'd0; rc = 4'd12; ld_en = 1'b1; ld_addr = 4'd12; ld_data = 32'hAA;
        tick();
        start = 1'b0; ld_en = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("busy_start_done_cnt", ndone, 1);
        peek(4'd11, v); chk("busy_start_r11", v, 32'd7);
        peek(4'd12, v); chk("busy_ld_r12", v, 32'd0);

        run(4'd4, 4'd2, 4'd5, 4'd12, 1'b0, 32'd0, lat);
        peek(4'd12, v); chk("xor_r12", v, 32'd1);
        run(4'd8, 4'd0, 4'd2, 4'd13, 1'b0, 32'd0, lat);
        peek(4'd13, v); chk("not_r13", v, 32'hFFFF_FFF8);
        run(4'd2, 4'd2, 4'd5, 4'd14, 1'b0, 32'd0, lat);
        peek(4'd14, v); chk("and_r14", v, 32'd6);
        run(4'd6, 4'd13, 4'd0, 4'd8, 1'b1, 32'h84, lat);
        peek(4'd8, v); chk("shr_r8", v, 32'h0FFF_FFFF);
        load(4'd15, 32'hAA);
        run(4'd9, 4'd2, 4'd5, 4'd15, 1'b0, 32'd0, lat);
        chk("rsv_lat", lat, 3);
        peek(4'd15, v); chk("rsv_r15", v, 32'd0);
        chk("rsv_result", result, 32'd0);

`ifdef DP_R0_ZERO_EN
        load(4'd0, 32'd9);
        peek(4'd0, v); chk("r0z_ld", v, 32'd0);
        run(4'd0, 4'd2, 4'd5, 4'd0, 1'b0, 32'd0, lat);
        chk("r0z_lat", lat, 3);
        peek(4'd0, v); chk("r0z_add", v, 32'd0);
        chk("r0z_result", result, 32'd13);
`else
        load(4'd0, 32'd9);
        peek(4'd0, v); chk("r0_ld", v, 32'd9);
        run(4'd0, 4'd2, 4'd5, 4'd0, 1'b0, 32'd0, lat);
        peek(4'd0, v); chk("r0_add", v, 32'd13);
`endif

        // clear while in TB of an ADD.
        op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; imm_sel = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy_done", {busy, done}, 2'b00);
        chk("clr_result_hilo", {result, hi, lo}, 96'd0);
        acc = 32'd0;
        for (int i = 0; i < 16; i++) begin
            peek(i[3:0], v);
            acc = acc | v;
        end
        chk("clr_all_gpr", acc, 32'd0);
        tick();
        chk("clr_stays_idle", {busy, done}, 2'b00);
        load(4'd1, 32'd3);
        load(4'd2, 32'd4);
        run(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, lat);
        peek(4'd3, v); chk("post_clr_add", v, 32'd7);

        // 8-bit instance: wraparound ADD, signed MUL, SHL amount modulo 8.
        bload(2'd1, 8'hF0);
        bload(2'd2, 8'h20);
        brun(4'd0, 2'd1, 2'd2, 2'd3, 1'b0, 8'd0);
        b_dbg_addr = 2'd3; #1;
        chk("w8_add", b_dbg_data, 8'h10);
        brun(4'd7, 2'd1, 2'd2, 2'd0, 1'b0, 8'd0);
        chk("w8_mul_hilo", {b_hi, b_lo}, 16'hFE00);
        brun(4'd5, 2'd3, 2'd0, 2'd2, 1'b1, 8'h0B);
        b_dbg_addr = 2'd2; #1;
        chk("w8_shl", b_dbg_data, 8'h80);
        chk("w8_idle", {b_busy, b_done}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
